mbm_r4_hs: RTL

//   Parametrised sequential radix-4 (modified) Booth multiplier; next generation of the 32-bit MBM.

---
 rtl/mbm_pkg.sv | 33 +++
 rtl/booth_r4_pp.sv | 32 +++
 rtl/mbm_r4_hs.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mbm_pkg.sv
// Shared types for the radix-4 Booth multiplier family.
//   state_t      : control FSM states of mbm_r4_hs
//   booth_dig_t  : recoded radix-4 Booth digit
//   booth_decode : maps the triplet {q[1], q[0], q[-1]} onto a Booth digit
package mbm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_dig_t;

  function automatic booth_dig_t booth_decode(input logic [2:0] trip);
    booth_dig_t dig;
    case (trip)
      3'b000, 3'b111: dig = ZERO;
      3'b001, 3'b010: dig = POS1;
      3'b011:         dig = POS2;
      3'b100:         dig = NEG2;
      default:        dig = NEG1;  // 101, 110
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial-product generator (combinational).
//   trip_i : Booth triplet {q[1], q[0], qm1}
//   m_i    : multiplicand, already extended to WIDTH+2 bits
//   pp_o   : signed addend (0, +-M, +-2M) sign-extended to WIDTH+4 bits
module booth_r4_pp
  import mbm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       trip_i,
  input  logic [WIDTH+1:0] m_i,
  output logic [WIDTH+3:0] pp_o
);

  logic [WIDTH+3:0] m1;
  logic [WIDTH+3:0] m2;

  assign m1 = {{2{m_i[WIDTH+1]}}, m_i};
  assign m2 = {m_i[WIDTH+1], m_i, 1'b0};

  always_comb begin
    pp_o = '0;
    case (booth_decode(trip_i))
      POS1:    pp_o = m1;
      POS2:    pp_o = m2;
      NEG1:    pp_o = '0 - m1;
      NEG2:    pp_o = '0 - m2;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mbm_r4_hs.sv
// Sequential radix-4 Booth multiplier with valid/ready handshakes.
// One operation in flight; result appears WIDTH/2+1 clock edges after accept.
//   clk, n_rst          : clock (rising edge), async active-low reset
//   in_valid / in_ready : request handshake; mcand, mplier, is_signed sampled on accept
//   out_valid/out_ready : response handshake; product held stable while out_valid
//   product             : full 2*WIDTH-bit product
module mbm_r4_hs
  import mbm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N     = WIDTH / 2 + 1;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("mbm_r4_hs: WIDTH must be even and >= 4");
  end

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH+3:0]       acc_q, acc_d;
  logic [WIDTH+1:0]       q_q, q_d;
  logic                   qm1_q, qm1_d;
  logic [WIDTH+1:0]       m_q, m_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;

  logic [WIDTH+3:0]       pp;
  logic [WIDTH+3:0]       sum;
  logic signed [2*WIDTH+6:0] cat;
  logic signed [2*WIDTH+6:0] sh;
  logic [WIDTH+3:0]       acc_n;
  logic [WIDTH+1:0]       q_n;
  logic                   qm1_n;

  function automatic logic [WIDTH+1:0] extend(input logic [WIDTH-1:0] x, input logic s);
    return {{2{s & x[WIDTH-1]}}, x};
  endfunction

  booth_r4_pp #(
    .WIDTH(WIDTH)
  ) u_pp (
    .trip_i({q_q[1:0], qm1_q}),
    .m_i   (m_q),
    .pp_o  (pp)
  );

  // Add the digit, then shift the whole {acc,q,qm1} chain right by two
  // as one signed vector so acc's sign propagates into the top bits.
  assign sum   = acc_q + pp;
  assign cat   = {sum, q_q, qm1_q};
  assign sh    = cat >>> 2;
  assign acc_n = sh[2*WIDTH+6 -: WIDTH+4];
  assign q_n   = sh[WIDTH+2:1];
  assign qm1_n = sh[0];

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    prod_d  = prod_q;

    case (state_q)
      CALC: begin
        acc_d = acc_n;
        q_d   = q_n;
        qm1_d = qm1_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          prod_d  = {acc_n[WIDTH-3:0], q_n};
        end
      end
      DONE: begin
        if (out_ready && !in_valid) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (in_valid && in_ready) begin
      state_d = CALC;
      acc_d   = '0;
      q_d     = extend(mplier, is_signed);
      qm1_d   = 1'b0;
      m_d     = extend(mcand, is_signed);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      prod_q  <= prod_d;
    end
  end

endmodule
